// File: rtl/csi2_data_types_pkg.sv
// Shared CSI-2 short packet definitions: data type codes, header layout and TX FSM states.
// Used by both the transmit generator and the receive-side parser.
package csi2_data_types_pkg;

    localparam logic [5:0] DT_FS = 6'h00;
    localparam logic [5:0] DT_FE = 6'h01;
    localparam logic [5:0] DT_LS = 6'h02;
    localparam logic [5:0] DT_LE = 6'h03;

    localparam int NUM_TYPES = 4;

    typedef struct packed {
        logic [7:0] ecc;
        logic [7:0] wc_msb;
        logic [7:0] wc_lsb;
        logic [7:0] di;
    } csi2_short_pkt_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } csi2_tx_state_e;

    // Encoding doubles as the bit index into the pending-flag vector.
    typedef enum logic [1:0] {
        SEL_FS = 2'd0,
        SEL_FE = 2'd1,
        SEL_LS = 2'd2,
        SEL_LE = 2'd3
    } csi2_pkt_sel_e;

endpackage

// File: rtl/csi2_ecc_gen.sv
// CSI-2 packet header ECC: 6-bit Hamming parity over the 24 header bits, top two bits zero.
// Purely combinational so the RX checker and long-packet header path can share it.
module csi2_ecc_gen (
    input  logic [23:0] data_i,
    output logic [7:0]  ecc_o
);

    assign ecc_o[0] = data_i[0]  ^ data_i[1]  ^ data_i[2]  ^ data_i[4]  ^ data_i[5]  ^
                      data_i[7]  ^ data_i[10] ^ data_i[11] ^ data_i[13] ^ data_i[16] ^
                      data_i[20] ^ data_i[21] ^ data_i[22] ^ data_i[23];
    assign ecc_o[1] = data_i[0]  ^ data_i[1]  ^ data_i[3]  ^ data_i[4]  ^ data_i[6]  ^
                      data_i[8]  ^ data_i[10] ^ data_i[12] ^ data_i[14] ^ data_i[17] ^
                      data_i[20] ^ data_i[21] ^ data_i[22] ^ data_i[23];
    assign ecc_o[2] = data_i[0]  ^ data_i[2]  ^ data_i[3]  ^ data_i[5]  ^ data_i[6]  ^
                      data_i[9]  ^ data_i[11] ^ data_i[12] ^ data_i[15] ^ data_i[18] ^
                      data_i[20] ^ data_i[21] ^ data_i[22];
    assign ecc_o[3] = data_i[1]  ^ data_i[2]  ^ data_i[3]  ^ data_i[7]  ^ data_i[8]  ^
                      data_i[9]  ^ data_i[13] ^ data_i[14] ^ data_i[15] ^ data_i[19] ^
                      data_i[20] ^ data_i[21] ^ data_i[23];
    assign ecc_o[4] = data_i[4]  ^ data_i[5]  ^ data_i[6]  ^ data_i[7]  ^ data_i[8]  ^
                      data_i[9]  ^ data_i[16] ^ data_i[17] ^ data_i[18] ^ data_i[19] ^
                      data_i[20] ^ data_i[22] ^ data_i[23];
    assign ecc_o[5] = data_i[10] ^ data_i[11] ^ data_i[12] ^ data_i[13] ^ data_i[14] ^
                      data_i[15] ^ data_i[16] ^ data_i[17] ^ data_i[18] ^ data_i[19] ^
                      data_i[21] ^ data_i[22] ^ data_i[23];
    assign ecc_o[7:6] = 2'b00;

endmodule

// File: rtl/csi2_short_pkt_gen.sv
// CSI-2 short packet transmitter: turns FS/FE/LS/LE request pulses into headers with ECC
// and keeps the frame and line counters that feed the data field.
module csi2_short_pkt_gen
    import csi2_data_types_pkg::*;
#(
    parameter logic [1:0]  VC            = 2'd0,
    parameter logic [15:0] FRAME_NUM_MAX = 16'd0,
    parameter logic        LINE_NUM_EN   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        frame_start_req_i,
    input  logic        frame_end_req_i,
    input  logic        line_start_req_i,
    input  logic        line_end_req_i,
    output logic [31:0] pkt_o,
    output logic        pkt_valid_o,
    input  logic        pkt_ready_i,
    output logic [15:0] frame_number_o,
    output logic [15:0] line_number_o,
    output logic        overflow_o
);

    csi2_tx_state_e  state_q, state_d;
    csi2_pkt_sel_e   sel_q, sel_d;
    csi2_short_pkt_t pkt_q, pkt_d;
    logic [3:0]      pend_q, pend_d;
    logic            valid_q, valid_d;
    logic [15:0]     frame_q, frame_d;
    logic [15:0]     line_q, line_d;
    logic            overflow_q, overflow_d;

    logic [3:0]      req, clr, ovf_hit;
    logic            load, handshake;
    csi2_pkt_sel_e   win;
    logic [15:0]     frame_inc, line_inc, wc;
    logic [5:0]      dt;
    logic [23:0]     hdr;
    logic [7:0]      ecc;

    assign req       = {line_end_req_i, line_start_req_i, frame_end_req_i, frame_start_req_i};
    assign load      = (state_q == TX_IDLE) && (|pend_q);
    assign handshake = (state_q == TX_SEND) && valid_q && pkt_ready_i;

    // A request landing on the clearing handshake re-arms the flag and is not an overflow.
    genvar gi;
    for (gi = 0; gi < NUM_TYPES; gi++) begin : g_pend
        assign clr[gi]     = handshake && (sel_q == 2'(gi));
        assign pend_d[gi]  = req[gi] || (pend_q[gi] && !clr[gi]);
        assign ovf_hit[gi] = req[gi] && pend_q[gi] && !clr[gi];
    end

    always_comb begin
        win = SEL_LS;
        if (pend_q[SEL_LE])      win = SEL_LE;
        else if (pend_q[SEL_FE]) win = SEL_FE;
        else if (pend_q[SEL_FS]) win = SEL_FS;
    end

    // Frame counter also wraps at 16'hFFFF so it stays in 1.. when the field is disabled.
    assign frame_inc = ((frame_q == FRAME_NUM_MAX) || (frame_q == 16'hFFFF)) ? 16'd1 : frame_q + 16'd1;
    assign line_inc  = (line_q == 16'hFFFF) ? 16'd1 : line_q + 16'd1;

    always_comb begin
        dt = DT_LS;
        wc = 16'd0;
        case (win)
            SEL_FS: begin dt = DT_FS; wc = (FRAME_NUM_MAX == 16'd0) ? 16'd0 : frame_inc; end
            SEL_FE: begin dt = DT_FE; wc = (FRAME_NUM_MAX == 16'd0) ? 16'd0 : frame_q;   end
            SEL_LS: begin dt = DT_LS; wc = LINE_NUM_EN ? line_inc : 16'd0;                end
            SEL_LE: begin dt = DT_LE; wc = LINE_NUM_EN ? line_q   : 16'd0;                end
        endcase
    end

    assign hdr = {wc, VC, dt};

    csi2_ecc_gen u_ecc (
        .data_i (hdr),
        .ecc_o  (ecc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= TX_IDLE;
            sel_q      <= SEL_FS;
            pkt_q      <= '0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            frame_q    <= '0;
            line_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pkt_q      <= pkt_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            line_q     <= line_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: if (|pend_q) state_d = TX_SEND;
            TX_SEND: if (valid_q && pkt_ready_i) state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        pkt_d      = pkt_q;
        valid_d    = valid_q;
        sel_d      = sel_q;
        frame_d    = frame_q;
        line_d     = line_q;
        overflow_d = overflow_q | (|ovf_hit);
        if (load) begin
            pkt_d   = {ecc, hdr};
            valid_d = 1'b1;
            sel_d   = win;
            if (win == SEL_FS) begin
                frame_d = frame_inc;
                line_d  = 16'd0;
            end else if (win == SEL_LS) begin
                line_d  = line_inc;
            end
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    assign pkt_o          = pkt_q;
    assign pkt_valid_o    = valid_q;
    assign frame_number_o = frame_q;
    assign line_number_o  = line_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_csi2_short_pkt_gen.sv
// Scoreboard bench: stimulus pushes expected headers, per-DUT monitors pop on each handshake.
// Instance A: VC0, frame wrap 3, line numbers on. Instance B: VC3, both data fields disabled.
module tb_csi2_short_pkt_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fs_req = 1'b0, fe_req = 1'b0, ls_req = 1'b0, le_req = 1'b0;
    logic rdy = 1'b1;
    logic [31:0] pkt_a, pkt_b;
    logic        val_a, val_b, ovf_a, ovf_b;
    logic [15:0] fn_a, ln_a, fn_b, ln_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int last_req_cyc = 0;
    int hs_cyc[$];

    typedef struct {
        logic [31:0] pkt;
        logic [15:0] frame;
        logic [15:0] line;
    } exp_t;

    exp_t        qa[$];
    logic [31:0] qb[$];

    int m_frame_a = 0, m_line_a = 0, m_frame_b = 0, m_line_b = 0;
    localparam int A_MAX = 3;

    // Syndrome column for each header bit; the ECC is the XOR of the columns of all set bits.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csi2_short_pkt_gen #(.VC(2'd0), .FRAME_NUM_MAX(16'd3), .LINE_NUM_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .frame_start_req_i(fs_req), .frame_end_req_i(fe_req),
        .line_start_req_i(ls_req), .line_end_req_i(le_req),
        .pkt_o(pkt_a), .pkt_valid_o(val_a), .pkt_ready_i(rdy),
        .frame_number_o(fn_a), .line_number_o(ln_a), .overflow_o(ovf_a));

    csi2_short_pkt_gen #(.VC(2'd3), .FRAME_NUM_MAX(16'd0), .LINE_NUM_EN(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .frame_start_req_i(fs_req), .frame_end_req_i(fe_req),
        .line_start_req_i(ls_req), .line_end_req_i(le_req),
        .pkt_o(pkt_b), .pkt_valid_o(val_b), .pkt_ready_i(rdy),
        .frame_number_o(fn_b), .line_number_o(ln_b), .overflow_o(ovf_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  e;
        d = {wc, vc, dt};
        e = 6'd0;
        for (int i = 0; i < 24; i++)
            if (d[i]) e ^= ECC_COL[i];
        return {2'b00, e, d};
    endfunction

    // kind: 0 FS, 1 FE, 2 LS, 3 LE (equal to the data type code)
    task automatic model_one(input int kind);
        exp_t e;
        int   wa;
        wa = 0;
        case (kind)
            0: begin
                m_frame_a = (m_frame_a >= A_MAX) ? 1 : m_frame_a + 1;
                m_frame_b = (m_frame_b >= 65535) ? 1 : m_frame_b + 1;
                m_line_a = 0; m_line_b = 0;
                wa = m_frame_a;
            end
            1: wa = m_frame_a;
            2: begin
                m_line_a = (m_line_a >= 65535) ? 1 : m_line_a + 1;
                m_line_b = (m_line_b >= 65535) ? 1 : m_line_b + 1;
                wa = m_line_a;
            end
            default: wa = m_line_a;
        endcase
        e.pkt   = mk_pkt(2'd0, 6'(kind), 16'(wa));
        e.frame = 16'(m_frame_a);
        e.line  = 16'(m_line_a);
        qa.push_back(e);
        qb.push_back(mk_pkt(2'd3, 6'(kind), 16'd0));
    endtask

    // reqs bit 0 FS, 1 FE, 2 LS, 3 LE; one-cycle pulse
    task automatic pulse(input logic [3:0] reqs);
        @(posedge clk); #1;
        last_req_cyc = cyc;
        fs_req = reqs[0]; fe_req = reqs[1]; ls_req = reqs[2]; le_req = reqs[3];
        @(posedge clk); #1;
        fs_req = 1'b0; fe_req = 1'b0; ls_req = 1'b0; le_req = 1'b0;
    endtask

    task automatic issue(input logic [3:0] reqs);
        pulse(reqs);
        if (reqs[3]) model_one(3);
        if (reqs[1]) model_one(1);
        if (reqs[0]) model_one(0);
        if (reqs[2]) model_one(2);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (val_a !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, val_a}, 32'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom % 2);
                default: rdy = 1'b0;
            endcase
        end
    end

    initial begin : mon_a
        exp_t        e;
        logic        hold;
        logic [31:0] hold_pkt;
        int          n;
        hold = 1'b0; hold_pkt = '0; n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("a_stall_valid", {31'd0, val_a}, 32'd1);
                    chk("a_stall_pkt", pkt_a, hold_pkt);
                end
                if (val_a && rdy) begin
                    if (qa.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL a_unexpected got=%h want=no_packet", pkt_a);
                    end else begin
                        e = qa.pop_front();
                        chk("a_pkt", pkt_a, e.pkt);
                        chk("a_frame_num", {16'd0, fn_a}, {16'd0, e.frame});
                        chk("a_line_num", {16'd0, ln_a}, {16'd0, e.line});
                        $display("tx A #%0d cyc=%0d pkt=%h frame=%0d line=%0d", n, cyc, pkt_a, fn_a, ln_a);
                    end
                    hs_cyc.push_back(cyc);
                    n++;
                end
                hold = val_a && !rdy;
                hold_pkt = pkt_a;
            end
        end
    end

    initial begin : mon_b
        logic [31:0] want;
        forever begin
            @(negedge clk);
            if (!rst && val_b && rdy) begin
                if (qb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected got=%h want=no_packet", pkt_b);
                end else begin
                    want = qb.pop_front();
                    chk("b_pkt", pkt_b, want);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0, nh;
        int wrap_seq[4];
        logic [3:0] r;
        wrap_seq = '{2, 3, 1, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pkt", pkt_a, 32'd0);
        chk("rst_valid", {31'd0, val_a}, 32'd0);
        chk("rst_frame", {16'd0, fn_a}, 32'd0);
        chk("rst_line", {16'd0, ln_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        rst = 1'b0;

        // FS after reset: latency and fixed header
        rdy_mode = 0;
        issue(4'b0001);
        wait_valid("t1_valid");
        chk("t1_latency", 32'(cyc - last_req_cyc), 32'd2);
        chk("t1_pkt", pkt_a, 32'h1A00_0100);
        chk("t1_frame", {16'd0, fn_a}, 32'd1);
        wait_drain("t1_drain");

        // LS numbering, then LS and LE
        issue(4'b0100);
        wait_valid("t2_valid");
        chk("t2_pkt", pkt_a, 32'h1100_0102);
        chk("t2_line", {16'd0, ln_a}, 32'd1);
        wait_drain("t2_drain");
        issue(4'b0100);
        wait_drain("t2_ls2_drain");
        issue(4'b1000);
        wait_drain("t2_le_drain");

        // all four at once: priority order and one idle cycle between packets
        n0 = hs_cyc.size();
        issue(4'b1111);
        wait_drain("t3_drain");
        for (int i = 1; i < 4; i++)
            chk("t3_gap", 32'(hs_cyc[n0 + i] - hs_cyc[n0 + i - 1]), 32'd2);

        // backpressure with a duplicate FS request
        rdy_mode = 2;
        nh = hs_cyc.size();
        issue(4'b0001);
        wait_valid("t4_valid");
        pulse(4'b0001);
        repeat (10) @(negedge clk);
        chk("t4_ovf_a", {31'd0, ovf_a}, 32'd1);
        chk("t4_ovf_b", {31'd0, ovf_b}, 32'd1);
        rdy_mode = 0;
        wait_drain("t4_drain");
        repeat (8) @(negedge clk);
        chk("t4_single_fs", 32'(hs_cyc.size() - nh), 32'd1);

        // asynchronous reset while a packet is waiting
        rdy_mode = 2;
        issue(4'b0001);
        wait_valid("t6_valid");
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_low", {31'd0, val_a}, 32'd0);
        chk("t6_frame", {16'd0, fn_a}, 32'd0);
        chk("t6_line", {16'd0, ln_a}, 32'd0);
        chk("t6_ovf", {31'd0, ovf_a}, 32'd0);
        qa.delete(); qb.delete();
        m_frame_a = 0; m_line_a = 0; m_frame_b = 0; m_line_b = 0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        issue(4'b0001);
        wait_drain("t6_drain");
        chk("t6_first_fs", {16'd0, fn_a}, 32'd1);

        // frame wrap 1,2,3,1,2
        for (int i = 0; i < 4; i++) begin
            issue(4'b0001);
            wait_drain("t5_drain");
            chk("t5_frame", {16'd0, fn_a}, 32'(wrap_seq[i]));
        end

        // randomized request sets under random backpressure
        for (int k = 0; k < 40; k++) begin
            rdy_mode = int'($urandom_range(0, 1));
            r = 4'($urandom_range(1, 15));
            issue(r);
            wait_drain("rand_drain");
        end

        rdy_mode = 0;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
